ex_mdu: RTL and testbench

EX_MDU -- requirements
Module: ex_mdu

---
 rtl/ex_mdu.sv | 221 ++++++++++++++++++++++
 tb/tb_ex_mdu.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mdu.sv
// ex_mdu: execute stage with single-cycle ALU/branch logic and an iterative multiply/divide unit
module ex_mdu #(
  parameter int XLEN = 32,
  parameter bit MUL_FAST = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_wen_i,
  input  logic            flush_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o,
  output logic [XLEN-1:0] jump_addr_o,
  output logic            jump_en_o,
  output logic            hold_flag_o
);
  localparam int SW = $clog2(XLEN);
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BR = 7'b1100011;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic is_mop, alt;
  assign opcode = inst_i[6:0];
  assign f3 = inst_i[14:12];
  assign f7 = inst_i[31:25];
  assign alt = inst_i[30];
  assign is_mop = opcode == OPC_OP && f7 == 7'b0000001;

  logic unused;
  assign unused = ^inst_i[24:15];

  logic [SW-1:0] shamt;
  logic [XLEN-1:0] add_r, alu_res, b_imm, sc_data, sc_target;
  logic lt, ltu, sc_ok, sc_wr, sc_jump, imm_ok, op_ok;
  assign shamt = op2_i[SW-1:0];
  assign lt = $signed(op1_i) < $signed(op2_i);
  assign ltu = op1_i < op2_i;
  assign add_r = (opcode == OPC_OP && alt) ? op1_i - op2_i : op1_i + op2_i;
  assign b_imm = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign op_ok = f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
  assign imm_ok = f3[1:0] != 2'b01 || inst_i[31:26] == 6'b0 || (f3[2] && inst_i[31:26] == 6'b010000);

  // ALU result shared by OP and OP-IMM
  always_comb begin
    alu_res = add_r;
    case (f3)
      3'b001: alu_res = op1_i << shamt;
      3'b010: alu_res = {{(XLEN-1){1'b0}}, lt};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, ltu};
      3'b100: alu_res = op1_i ^ op2_i;
      3'b101: alu_res = alt ? XLEN'($signed(op1_i) >>> shamt) : op1_i >> shamt;
      3'b110: alu_res = op1_i | op2_i;
      3'b111: alu_res = op1_i & op2_i;
      default: alu_res = add_r;
    endcase
  end

  // single-cycle decode: legality, writeback value and redirect target
  always_comb begin
    sc_ok = 1'b0;
    sc_wr = 1'b0;
    sc_jump = 1'b0;
    sc_data = '0;
    sc_target = '0;
    case (opcode)
      OPC_IMM: begin
        sc_ok = imm_ok;
        sc_wr = imm_ok;
        sc_data = alu_res;
      end
      OPC_OP: begin
        sc_ok = op_ok;
        sc_wr = op_ok;
        sc_data = alu_res;
      end
      OPC_LUI: begin
        sc_ok = 1'b1;
        sc_wr = 1'b1;
        sc_data = op1_i;
      end
      OPC_AUIPC: begin
        sc_ok = 1'b1;
        sc_wr = 1'b1;
        sc_data = inst_addr_i + op1_i;
      end
      OPC_JAL: begin
        sc_ok = 1'b1;
        sc_wr = 1'b1;
        sc_jump = 1'b1;
        sc_data = inst_addr_i + XLEN'(4);
        sc_target = inst_addr_i + op1_i;
      end
      OPC_JALR: begin
        sc_ok = f3 == 3'b000;
        sc_wr = f3 == 3'b000;
        sc_jump = f3 == 3'b000;
        sc_data = inst_addr_i + XLEN'(4);
        sc_target = (op1_i + op2_i) & ~XLEN'(1);
      end
      OPC_BR: begin
        sc_ok = f3[2:1] != 2'b01;
        sc_jump = sc_ok && ((f3[2] ? (f3[1] ? ltu : lt) : op1_i == op2_i) ^ f3[0]);
        sc_target = inst_addr_i + b_imm;
      end
      default: sc_ok = 1'b0;
    endcase
  end

  logic sgn1, sgn2, s1, s2, is_div, div_zero, div_ovf, fast, start;
  logic [XLEN-1:0] a_mag, b_mag, ld_hi, ld_lo;
  logic [2*XLEN-1:0] prod_fast;
  assign sgn1 = ~(f3[0] & (f3[1] | f3[2]));
  assign sgn2 = sgn1 && f3 != 3'b010;
  assign s1 = sgn1 & op1_i[XLEN-1];
  assign s2 = sgn2 & op2_i[XLEN-1];
  assign a_mag = s1 ? -op1_i : op1_i;
  assign b_mag = s2 ? -op2_i : op2_i;
  assign is_div = f3[2];
  assign div_zero = is_div && op2_i == '0;
  assign div_ovf = is_div && !f3[0] && op1_i == MIN && op2_i == '1;
  assign fast = MUL_FAST && !is_div;
  assign prod_fast = MUL_FAST ? {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag} : '0;
  assign ld_hi = div_zero ? op1_i : fast ? prod_fast[2*XLEN-1:XLEN] : '0;
  assign ld_lo = div_zero ? '1 : div_ovf ? MIN : fast ? prod_fast[XLEN-1:0] : is_div ? a_mag : b_mag;
  assign start = state == IDLE && is_mop && !flush_i;

  logic [XLEN-1:0] hi, lo, bm;
  logic [SW-1:0] cnt;
  logic [2:0] f3_q;
  logic [4:0] rd_q;
  logic neg_q, neg_r;

  logic [XLEN:0] mul_sum, div_tmp, div_dif;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] m_result;
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, bm} : '0);
  assign div_tmp = {hi, lo[XLEN-1]};
  assign div_dif = div_tmp - {1'b0, bm};
  assign prod_s = neg_q ? -{hi, lo} : {hi, lo};
  assign m_result = f3_q[2] ? (f3_q[1] ? (neg_r ? -hi : hi) : (neg_q ? -lo : lo))
                  : (f3_q[1:0] == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);

  // M-unit next state: shortcuts and fast multiply skip the iteration
  always_comb begin
    state_nx = flush_i ? IDLE
             : start ? ((div_zero || div_ovf || fast) ? DONE : BUSY)
             : state == BUSY ? (cnt == SW'(XLEN-1) ? DONE : BUSY)
             : IDLE;
  end

  // M-unit registers: operand latch on start, one shift-add or restoring step per busy cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      bm <= '0;
      cnt <= '0;
      f3_q <= '0;
      rd_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) begin
        hi <= ld_hi;
        lo <= ld_lo;
        bm <= is_div ? b_mag : a_mag;
        cnt <= '0;
        f3_q <= f3;
        rd_q <= rd_addr_i;
        neg_q <= !(div_zero || div_ovf) && (s1 ^ s2);
        neg_r <= !(div_zero || div_ovf) && s1;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        hi <= f3_q[2] ? (div_dif[XLEN] ? div_tmp[XLEN-1:0] : div_dif[XLEN-1:0]) : mul_sum[XLEN:1];
        lo <= f3_q[2] ? {lo[XLEN-2:0], ~div_dif[XLEN]} : {mul_sum[0], lo[XLEN-1:1]};
      end
    end
  end

  // output mux: reset forces zeros, M-unit owns outputs while busy or done
  always_comb begin
    rd_addr_o = '0;
    rd_data_o = '0;
    rd_wen_o = 1'b0;
    jump_addr_o = '0;
    jump_en_o = 1'b0;
    hold_flag_o = 1'b0;
    if (rst_n) begin
      if (state == DONE) begin
        rd_addr_o = rd_q;
        rd_data_o = m_result;
        rd_wen_o = !flush_i;
      end else if (state == BUSY || is_mop) begin
        hold_flag_o = !flush_i;
      end else if (sc_ok) begin
        rd_addr_o = sc_wr ? rd_addr_i : '0;
        rd_data_o = sc_wr ? sc_data : '0;
        rd_wen_o = sc_wr && rd_wen_i && !flush_i;
        jump_en_o = sc_jump;
        jump_addr_o = sc_jump ? sc_target : '0;
      end
    end
  end
endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed self-checking bench for ex_mdu
module tb_ex_mdu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] inst_i = '0, inst_addr_i = '0, op1_i = '0, op2_i = '0;
  logic [4:0] rd_addr_i = '0;
  logic rd_wen_i = 1'b0, flush_i = 1'b0;
  logic [4:0] rd_addr_o;
  logic [31:0] rd_data_o, jump_addr_o;
  logic rd_wen_o, jump_en_o, hold_flag_o;
  int checks = 0;
  int errors = 0;

  ex_mdu #(.XLEN(32), .MUL_FAST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i), .rd_wen_i(rd_wen_i),
    .flush_i(flush_i), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wen_o(rd_wen_o),
    .jump_addr_o(jump_addr_o), .jump_en_o(jump_en_o), .hold_flag_o(hold_flag_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 10'd0, f3, 5'd0, opc};
  endfunction

  function automatic logic [31:0] br(input logic [2:0] f3);
    return {7'd0, 10'd0, f3, 4'b0100, 1'b0, 7'h63};
  endfunction

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic wen);
    inst_i = inst;
    inst_addr_i = pc;
    op1_i = a;
    op2_i = b;
    rd_addr_i = rd;
    rd_wen_i = wen;
  endtask

  task automatic run_mop(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_hold);
    int hold_n;
    int early;
    bit done;
    hold_n = 0;
    early = 0;
    done = 1'b0;
    drive(enc(7'h01, f3, 7'h33), 32'h200, a, b, 5'd9, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!hold_flag_o) begin
        done = 1'b1;
        break;
      end
      if (rd_wen_o) early++;
      hold_n++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: hold still %b after %0d cycles, required drop after %0d", name, hold_flag_o, hold_n, exp_hold);
    end else begin
      checks += 4;
      if (hold_n !== exp_hold) begin errors++; $display("FAIL %s hold cycles: got %0d required %0d", name, hold_n, exp_hold); end
      if (rd_wen_o !== 1'b1 || early !== 0) begin errors++; $display("FAIL %s wen: done %b early %0d required 1/0", name, rd_wen_o, early); end
      if (rd_data_o !== exp) begin errors++; $display("FAIL %s data: got %h required %h", name, rd_data_o, exp); end
      if (rd_addr_o !== 5'd9) begin errors++; $display("FAIL %s rd: got %0d required 9", name, rd_addr_o); end
    end
    @(posedge clk);
    #1;
    drive('0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    drive(enc(7'h00, 3'b000, 7'h13), 32'h100, 32'd5, 32'hFFFFFFFB, 5'd3, 1'b1);
    @(negedge clk);
    checks++;
    if (rd_wen_o !== 0 || rd_data_o !== 0 || rd_addr_o !== 0 || hold_flag_o !== 0 || jump_en_o !== 0)
      begin errors++; $display("FAIL reset_alu: wen %b data %h rd %0d hold %b jmp %b required all 0", rd_wen_o, rd_data_o, rd_addr_o, hold_flag_o, jump_en_o); end
    drive(enc(7'h01, 3'b000, 7'h33), 32'h100, 32'd5, 32'd6, 5'd3, 1'b1);
    #1;
    checks++;
    if (hold_flag_o !== 0 || rd_wen_o !== 0) begin errors++; $display("FAIL reset_mop: hold %b wen %b required 0 0", hold_flag_o, rd_wen_o); end
    @(posedge clk);
    #1;
    drive('0, '0, '0, '0, '0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (hold_flag_o !== 0 || rd_wen_o !== 0) begin errors++; $display("FAIL reset_idle: hold %b wen %b required 0 0", hold_flag_o, rd_wen_o); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu();
    logic [31:0] iv[10];
    logic [31:0] av[10];
    logic [31:0] bv[10];
    logic [31:0] ev[10];
    iv = '{enc(7'h00,3'b000,7'h13), enc(7'h20,3'b000,7'h33), enc(7'h20,3'b101,7'h33), enc(7'h00,3'b101,7'h33),
           enc(7'h00,3'b010,7'h33), enc(7'h00,3'b011,7'h33), enc(7'h00,3'b001,7'h13), enc(7'h00,3'b100,7'h13),
           32'h00000037, 32'h00000017};
    av = '{32'd5, 32'd3, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'hF0F0F0F0, 32'h12345000, 32'h1000};
    bv = '{32'hFFFFFFFB, 32'd5, 32'h24, 32'h24, 32'd1, 32'd1, 32'h1F, 32'hFFFFFFFF, 32'd0, 32'd0};
    ev = '{32'd0, 32'hFFFFFFFE, 32'hF8000000, 32'h08000000, 32'd1, 32'd0, 32'h80000000, 32'h0F0F0F0F, 32'h12345000, 32'h1100};
    for (int i = 0; i < 10; i++) begin
      drive(iv[i], 32'h100, av[i], bv[i], 5'd7, 1'b1);
      @(negedge clk);
      checks += 2;
      if (rd_data_o !== ev[i]) begin errors++; $display("FAIL alu[%0d] data: got %h required %h", i, rd_data_o, ev[i]); end
      if (rd_wen_o !== 1 || hold_flag_o !== 0 || rd_addr_o !== 5'd7)
        begin errors++; $display("FAIL alu[%0d] ctl: wen %b hold %b rd %0d required 1 0 7", i, rd_wen_o, hold_flag_o, rd_addr_o); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_jump();
    drive(32'h0000006F, 32'h100, 32'h20, 32'd0, 5'd1, 1'b1);
    @(negedge clk);
    checks++;
    if (jump_en_o !== 1 || jump_addr_o !== 32'h120 || rd_data_o !== 32'h104 || rd_wen_o !== 1)
      begin errors++; $display("FAIL jal: en %b addr %h data %h wen %b required 1 120 104 1", jump_en_o, jump_addr_o, rd_data_o, rd_wen_o); end
    @(posedge clk);
    #1;
    drive(32'h00000067, 32'h100, 32'h201, 32'h4, 5'd1, 1'b1);
    @(negedge clk);
    checks++;
    if (jump_en_o !== 1 || jump_addr_o !== 32'h204 || rd_data_o !== 32'h104)
      begin errors++; $display("FAIL jalr: en %b addr %h data %h required 1 204 104", jump_en_o, jump_addr_o, rd_data_o); end
    @(posedge clk);
    #1;
    drive(32'h0000007F, 32'h100, 32'h55, 32'h66, 5'd1, 1'b1);
    @(negedge clk);
    checks++;
    if (jump_en_o !== 0 || jump_addr_o !== 0 || rd_data_o !== 0 || rd_wen_o !== 0 || rd_addr_o !== 0 || hold_flag_o !== 0)
      begin errors++; $display("FAIL unknown: en %b addr %h data %h wen %b rd %0d hold %b required all 0", jump_en_o, jump_addr_o, rd_data_o, rd_wen_o, rd_addr_o, hold_flag_o); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_branch();
    logic [2:0] fv[4];
    logic ev[4];
    logic [31:0] tv[4];
    fv = '{3'b100, 3'b110, 3'b101, 3'b111};
    ev = '{1'b1, 1'b0, 1'b0, 1'b1};
    tv = '{32'h108, 32'h0, 32'h0, 32'h108};
    for (int i = 0; i < 4; i++) begin
      drive(br(fv[i]), 32'h100, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (jump_en_o !== ev[i] || jump_addr_o !== tv[i] || rd_wen_o !== 0)
        begin errors++; $display("FAIL branch[%0d]: en %b addr %h wen %b required %b %h 0", i, jump_en_o, jump_addr_o, rd_wen_o, ev[i], tv[i]); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mul();
    run_mop("mul", 3'b000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 33);
    run_mop("mulhu", 3'b011, 32'hFFFFFFFF, 32'd2, 32'h00000001, 33);
    run_mop("mulh", 3'b001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
    run_mop("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
    run_mop("mul_neg", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
  endtask

  task automatic test_div();
    run_mop("div", 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run_mop("rem", 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
    run_mop("div_negdvd", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_mop("rem_negdvd", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_mop("divu_zero", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_mop("remu_zero", 3'b111, 32'd5, 32'd0, 32'd5, 1);
    run_mop("rem_zero", 3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1);
    run_mop("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_mop("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    run_mop("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
  endtask

  task automatic test_flush();
    int bad;
    bad = 0;
    drive(enc(7'h01, 3'b000, 7'h33), 32'h200, 32'hFFFFFFFF, 32'd2, 5'd9, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_wen_o || !hold_flag_o) bad++;
      @(posedge clk);
      #1;
    end
    flush_i = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bad !== 0) begin errors++; $display("FAIL flush_pre: got %0d bad cycles required 0", bad); end
    if (hold_flag_o !== 0 || rd_wen_o !== 0) begin errors++; $display("FAIL flush_cycle: hold %b wen %b required 0 0", hold_flag_o, rd_wen_o); end
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    drive(enc(7'h00, 3'b000, 7'h33), 32'h204, 32'd2, 32'd3, 5'd4, 1'b1);
    @(negedge clk);
    checks++;
    if (rd_data_o !== 32'd5 || rd_wen_o !== 1 || hold_flag_o !== 0 || rd_addr_o !== 5'd4)
      begin errors++; $display("FAIL flush_add: data %h wen %b hold %b rd %0d required 5 1 0 4", rd_data_o, rd_wen_o, hold_flag_o, rd_addr_o); end
    @(posedge clk);
    #1;
    drive('0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive(enc(7'h01, 3'b100, 7'h33), 32'h200, 32'd100, 32'd7, 5'd9, 1'b1);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (hold_flag_o !== 0 || rd_wen_o !== 0 || rd_data_o !== 0)
      begin errors++; $display("FAIL rstmid_cycle: hold %b wen %b data %h required 0 0 0", hold_flag_o, rd_wen_o, rd_data_o); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(enc(7'h00, 3'b000, 7'h33), 32'h204, 32'd2, 32'd3, 5'd4, 1'b1);
    @(negedge clk);
    checks++;
    if (rd_data_o !== 32'd5 || rd_wen_o !== 1 || hold_flag_o !== 0)
      begin errors++; $display("FAIL rstmid_add: data %h wen %b hold %b required 5 1 0", rd_data_o, rd_wen_o, hold_flag_o); end
    @(posedge clk);
    #1;
    drive('0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_mop("b2b_mul", 3'b000, 32'd3, 32'd4, 32'd12, 33);
    drive(enc(7'h00, 3'b000, 7'h33), 32'h204, 32'd1, 32'd1, 5'd2, 1'b1);
    @(negedge clk);
    checks++;
    if (rd_data_o !== 32'd2 || rd_wen_o !== 1 || hold_flag_o !== 0)
      begin errors++; $display("FAIL b2b_add: data %h wen %b hold %b required 2 1 0", rd_data_o, rd_wen_o, hold_flag_o); end
    @(posedge clk);
    #1;
    run_mop("b2b_remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    run_mop("b2b_mulhu", 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33);
  endtask

  initial begin
    #1;
    test_reset();
    test_alu();
    test_jump();
    test_branch();
    test_mul();
    test_div();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
